// File: rtl/lcd_1602_rx_pkg.sv
// lcd_rx_t: shared state type, port_q bit positions and HD44780 constants
package lcd_rx_t;
    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_DATA, ST_DATA_ACK, ST_IGNORE
    } rx_state_t;
    localparam int P_RS = 0;
    localparam int P_RW = 1;
    localparam int P_EN = 2;
    localparam int P_BL = 3;
    localparam logic [6:0] ROW0_BASE = 7'h00;
    localparam logic [6:0] ROW1_BASE = 7'h40;
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
endpackage

// File: rtl/lcd_1602_rx_phy.sv
// i2c_target_phy: synchronized write-only I2C target with address match and ACK drive
module i2c_target_phy
    import lcd_rx_t::*;
#(
    parameter logic [6:0] ADDR = 7'h27,
    parameter int SYNC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    inout  wire        sda,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       addressed
);
    logic [SYNC-1:0] scl_sh, sda_sh;
    logic scl_s, sda_s, scl_p, sda_p, scl_rise, scl_fall, start, stop, last, oe;
    logic [2:0] cnt;
    logic [6:0] sh;
    logic [7:0] rx;
    rx_state_t st, nxt;

    assign scl_s    = scl_sh[SYNC-1];
    assign sda_s    = sda_sh[SYNC-1];
    assign scl_rise = scl_s & ~scl_p;
    assign scl_fall = ~scl_s & scl_p;
    assign start    = scl_s & scl_p & sda_p & ~sda_s;
    assign stop     = scl_s & scl_p & ~sda_p & sda_s;
    assign last     = scl_rise && cnt == 3'd7;
    assign rx       = {sh, sda_s};
    assign sda      = oe ? 1'b0 : 1'bz;

    // synchronize the bus lines and keep one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sh <= '1;
            sda_sh <= '1;
            scl_p  <= 1'b1;
            sda_p  <= 1'b1;
        end else begin
            scl_sh <= {scl_sh[SYNC-2:0], sclk};
            sda_sh <= {sda_sh[SYNC-2:0], sda};
            scl_p  <= scl_s;
            sda_p  <= sda_s;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) st <= ST_IDLE;
        else     st <= nxt;
    end

    // next state; START and STOP override whatever the byte logic wants
    always_comb begin
        nxt = st;
        case (st)
            ST_ADDR:                  if (last) nxt = (rx == {ADDR, 1'b0}) ? ST_ADDR_ACK : ST_IGNORE;
            ST_DATA:                  if (last) nxt = ST_DATA_ACK;
            ST_ADDR_ACK, ST_DATA_ACK: if (scl_fall && oe) nxt = ST_DATA;
            default:                  nxt = st;
        endcase
        if (start)     nxt = ST_ADDR;
        else if (stop) nxt = ST_IDLE;
    end

    // outputs decoded from state
    always_comb begin
        addressed = (st == ST_ADDR_ACK && oe) || st == ST_DATA || st == ST_DATA_ACK;
    end

    // shift register, bit counter, byte hand-off and ACK pull-down toggled on sclk falls
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            sh         <= '0;
            oe         <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
        end else begin
            byte_valid <= st == ST_DATA && last;
            if (st == ST_DATA && last) byte_data <= rx;
            if (start || stop) begin
                cnt <= '0;
                oe  <= 1'b0;
            end else if (scl_rise && (st == ST_ADDR || st == ST_DATA)) begin
                sh  <= rx[6:0];
                cnt <= cnt + 3'd1;
            end else if (scl_fall && (st == ST_ADDR_ACK || st == ST_DATA_ACK)) begin
                oe <= ~oe;
            end
        end
    end
endmodule

// File: rtl/lcd_1602_rx.sv
// lcd_1602_rx: PCF8574 backpack emulation decoding HD44780 nibble writes; DDRAM_EN adds a 32x8 display mirror
module lcd_1602_rx
    import lcd_rx_t::*;
#(
    parameter logic [6:0] ADDR = 7'h27,
    parameter int SYNC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    inout  wire        sda,
    output logic [7:0] port_q,
    output logic       lcd_valid,
    output logic       lcd_rs,
    output logic [7:0] lcd_byte,
    output logic       mode4,
    output logic       addressed,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data
);
    logic byte_valid, upd, strobe, phase_hi, prev_en, prev_rw, prev_rs;
    logic [7:0] byte_data;
    logic [3:0] prev_nib, hi;

    i2c_target_phy #(.ADDR(ADDR), .SYNC(SYNC)) u_phy (
        .clk(clk), .rst(rst), .sclk(sclk), .sda(sda),
        .byte_valid(byte_valid), .byte_data(byte_data), .addressed(addressed)
    );

    assign strobe = upd && prev_en && !port_q[P_EN] && !prev_rw;

    // expander image, falling-EN strobe decode and nibble assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            port_q    <= '0;
            prev_nib  <= '0;
            prev_en   <= 1'b0;
            prev_rw   <= 1'b0;
            prev_rs   <= 1'b0;
            upd       <= 1'b0;
            lcd_valid <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_byte  <= '0;
            mode4     <= 1'b0;
            phase_hi  <= 1'b1;
            hi        <= '0;
        end else begin
            upd       <= byte_valid;
            lcd_valid <= 1'b0;
            if (byte_valid) begin
                port_q   <= byte_data;
                prev_nib <= port_q[7:4];
                prev_en  <= port_q[P_EN];
                prev_rw  <= port_q[P_RW];
                prev_rs  <= port_q[P_RS];
            end
            if (strobe && !mode4) begin
                lcd_valid <= 1'b1;
                lcd_byte  <= {prev_nib, 4'h0};
                lcd_rs    <= prev_rs;
                if (!prev_rs && prev_nib == 4'h2) begin
                    mode4    <= 1'b1;
                    phase_hi <= 1'b1;
                end
            end else if (strobe && phase_hi) begin
                hi       <= prev_nib;
                phase_hi <= 1'b0;
            end else if (strobe) begin
                lcd_valid <= 1'b1;
                lcd_byte  <= {hi, prev_nib};
                lcd_rs    <= prev_rs;
                phase_hi  <= 1'b1;
            end
        end
    end

`ifdef DDRAM_EN
    logic [7:0] mem [32];
    logic [4:0] cursor, scnt;
    logic sweep, pend_v, pend_rs, xv, xrs;
    logic [7:0] pend_b, xb;

    assign xv  = !sweep && (pend_v || lcd_valid);
    assign xb  = pend_v ? pend_b : lcd_byte;
    assign xrs = pend_v ? pend_rs : lcd_rs;

    // mirror writes, cursor moves and the clear sweep with a one-deep hold for transfers during it
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h20;
            cursor  <= '0;
            scnt    <= '0;
            sweep   <= 1'b0;
            pend_v  <= 1'b0;
            pend_rs <= 1'b0;
            pend_b  <= '0;
        end else if (sweep) begin
            mem[scnt] <= 8'h20;
            scnt      <= scnt + 5'd1;
            sweep     <= scnt != 5'd31;
            if (lcd_valid) begin
                pend_v  <= 1'b1;
                pend_rs <= lcd_rs;
                pend_b  <= lcd_byte;
            end
        end else if (xv) begin
            pend_v <= 1'b0;
            if (xrs) begin
                mem[cursor] <= xb;
                cursor      <= {cursor[4], cursor[3:0] + 4'd1};
            end else if (xb == CMD_CLEAR) begin
                sweep  <= 1'b1;
                scnt   <= '0;
                cursor <= '0;
            end else if ((xb & CMD_SET_DDRAM) != 8'h00) begin
                cursor <= {|(xb[6:0] & ROW1_BASE), xb[3:0]};
            end
        end
    end

    // registered mirror read port
    always_ff @(posedge clk) begin
        if (rst) rd_data <= 8'h20;
        else     rd_data <= mem[rd_addr];
    end
`else
    logic unused_rd;
    assign unused_rd = ^rd_addr;
    assign rd_data   = 8'h00;
`endif
endmodule

// File: tb/tb_lcd_1602_rx.sv
// tb_lcd_1602_rx: bit-banged I2C master driving lcd_1602_rx with a scoreboard of expected LCD transfers
module tb_lcd_1602_rx;
    localparam int Q = 10;
    logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_low = 1'b0;
    logic [4:0] rd_addr = '0;
    wire sda;
    logic [7:0] port_q, lcd_byte, rd_data;
    logic lcd_valid, lcd_rs, mode4, addressed;
    int n_cmp = 0, n_bad = 0, nacks = 0;
    logic [8:0] exp_q [$];
    logic [8:0] e;
    logic lv_d = 1'b0, drv_seen = 1'b0, ack = 1'b0, addr_at_ack = 1'b0;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);
    always #5 clk = ~clk;

    lcd_1602_rx #(.ADDR(7'h27), .SYNC(2)) dut (
        .clk(clk), .rst(rst), .sclk(scl), .sda(sda), .port_q(port_q),
        .lcd_valid(lcd_valid), .lcd_rs(lcd_rs), .lcd_byte(lcd_byte), .mode4(mode4),
        .addressed(addressed), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // pops the expected transfer whenever the DUT reports one; also tracks DUT pull-downs
    always @(negedge clk) begin
        if (sda === 1'b0 && !m_low) drv_seen = 1'b1;
        if (lcd_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL lcd_transfer got rs=%0b byte=%02h required none", lcd_rs, lcd_byte);
            end else begin
                e = exp_q.pop_front();
                if ({lcd_rs, lcd_byte} !== e) begin
                    n_bad++;
                    $display("FAIL lcd_transfer got rs=%0b byte=%02h required rs=%0b byte=%02h", lcd_rs, lcd_byte, e[8], e[7:0]);
                end
            end
            n_cmp++;
            if (lv_d !== 1'b0) begin
                n_bad++;
                $display("FAIL lcd_valid_width got 2+ cycles required 1");
            end
        end
        lv_d = lcd_valid;
    end

    task automatic wq();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_low = 1'b0; wq(); scl = 1'b1; wq(); m_low = 1'b1; wq(); scl = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; wq(); scl = 1'b1; wq(); m_low = 1'b0; wq();
    endtask

    task automatic send_bit(input logic v);
        m_low = ~v; wq(); scl = 1'b1; wq(); wq(); scl = 1'b0; wq();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_low = 1'b0; wq(); scl = 1'b1; wq();
        ack = (sda === 1'b0);
        addr_at_ack = addressed;
        wq(); scl = 1'b0; wq();
        if (!ack) nacks++;
    endtask

    task automatic put4(input logic rs, input logic [7:0] b);
        send_byte({b[7:4], 3'b110, rs});
        send_byte({b[7:4], 3'b100, rs});
        send_byte({b[3:0], 3'b110, rs});
        exp_q.push_back({rs, b});
        send_byte({b[3:0], 3'b100, rs});
    endtask

    task automatic test_reset();
        rst = 1'b1; repeat (3) @(posedge clk); #1;
        rst = 1'b0; rd_addr = 5'd3; repeat (2) @(posedge clk); #1;
        n_cmp++; if (port_q !== 8'h00) begin n_bad++; $display("FAIL rst_port_q got %02h required 00", port_q); end
        n_cmp++; if (lcd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_lcd_valid got %0b required 0", lcd_valid); end
        n_cmp++; if (lcd_rs !== 1'b0) begin n_bad++; $display("FAIL rst_lcd_rs got %0b required 0", lcd_rs); end
        n_cmp++; if (lcd_byte !== 8'h00) begin n_bad++; $display("FAIL rst_lcd_byte got %02h required 00", lcd_byte); end
        n_cmp++; if (mode4 !== 1'b0) begin n_bad++; $display("FAIL rst_mode4 got %0b required 0", mode4); end
        n_cmp++; if (addressed !== 1'b0) begin n_bad++; $display("FAIL rst_addressed got %0b required 0", addressed); end
        n_cmp++; if (sda !== 1'b1) begin n_bad++; $display("FAIL rst_sda got %0b required 1", sda); end
`ifdef DDRAM_EN
        n_cmp++; if (rd_data !== 8'h20) begin n_bad++; $display("FAIL rst_ddram got %02h required 20", rd_data); end
`else
        n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL rst_rd_data got %02h required 00", rd_data); end
`endif
    endtask

    task automatic test_addr_ack();
        i2c_start();
        send_byte(8'h4E);
        n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL addr_ack got %0b required 1", ack); end
        n_cmp++; if (addr_at_ack !== 1'b1) begin n_bad++; $display("FAIL addressed_at_ack got %0b required 1", addr_at_ack); end
        i2c_stop();
        repeat (5) @(posedge clk); #1;
        n_cmp++; if (addressed !== 1'b0) begin n_bad++; $display("FAIL addressed_after_stop got %0b required 0", addressed); end
        n_cmp++; if (port_q !== 8'h00) begin n_bad++; $display("FAIL addr_only_port_q got %02h required 00", port_q); end
        n_cmp++; if (sda !== 1'b1) begin n_bad++; $display("FAIL sda_after_stop got %0b required 1", sda); end
    endtask

    task automatic test_addr_mismatch();
        int n0;
        n0 = nacks;
        drv_seen = 1'b0;
        i2c_start();
        send_byte(8'h4A);
        send_byte(8'h3C);
        i2c_stop();
        repeat (5) @(posedge clk); #1;
        n_cmp++; if (nacks - n0 !== 2) begin n_bad++; $display("FAIL mismatch_nacks got %0d required 2", nacks - n0); end
        n_cmp++; if (drv_seen !== 1'b0) begin n_bad++; $display("FAIL mismatch_sda_driven got %0b required 0", drv_seen); end
        n_cmp++; if (port_q !== 8'h00) begin n_bad++; $display("FAIL mismatch_port_q got %02h required 00", port_q); end
    endtask

    task automatic test_init();
        int n0;
        n0 = nacks;
        i2c_start();
        send_byte(8'h4E);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h3C);
            exp_q.push_back({1'b0, 8'h30});
            send_byte(8'h38);
        end
        send_byte(8'h2C);
        exp_q.push_back({1'b0, 8'h20});
        send_byte(8'h28);
        i2c_stop();
        repeat (5) @(posedge clk); #1;
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL init_pending got %0d required 0", exp_q.size()); end
        n_cmp++; if (mode4 !== 1'b1) begin n_bad++; $display("FAIL init_mode4 got %0b required 1", mode4); end
        n_cmp++; if (port_q !== 8'h28) begin n_bad++; $display("FAIL init_port_q got %02h required 28", port_q); end
        n_cmp++; if (nacks !== n0) begin n_bad++; $display("FAIL init_nacks got %0d required %0d", nacks, n0); end
    endtask

    task automatic test_cmd_data();
        int n0;
        n0 = nacks;
        i2c_start();
        send_byte(8'h4E);
        send_byte(8'h8C);
        send_byte(8'h88);
        send_byte(8'h8C);
        exp_q.push_back({1'b0, 8'h88});
        send_byte(8'h88);
        send_byte(8'h4D);
        send_byte(8'h49);
        i2c_stop();
        repeat (5) @(posedge clk); #1;
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL cmd88_pending got %0d required 0", exp_q.size()); end
        n_cmp++; if (port_q !== 8'h49) begin n_bad++; $display("FAIL split_port_q got %02h required 49", port_q); end
        i2c_start();
        send_byte(8'h4E);
        send_byte(8'h1D);
        exp_q.push_back({1'b1, 8'h41});
        send_byte(8'h19);
        i2c_stop();
        repeat (5) @(posedge clk); #1;
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL char41_pending got %0d required 0", exp_q.size()); end
        n_cmp++; if (nacks !== n0) begin n_bad++; $display("FAIL cmd_nacks got %0d required %0d", nacks, n0); end
`ifdef DDRAM_EN
        rd_addr = 5'd8; repeat (2) @(posedge clk); #1;
        n_cmp++; if (rd_data !== 8'h41) begin n_bad++; $display("FAIL ddram_8 got %02h required 41", rd_data); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [4:0] ra [6];
        logic [7:0] rv [6];
        ra = '{5'd15, 5'd0, 5'd1, 5'd16, 5'd17, 5'd8};
        rv = '{8'h5A, 8'h61, 8'h20, 8'h7E, 8'h20, 8'h41};
        i2c_start();
        send_byte(8'h4E);
        put4(1'b0, 8'h8F);
        put4(1'b1, 8'h5A);
        put4(1'b1, 8'h61);
        put4(1'b0, 8'hC0);
        put4(1'b1, 8'h7E);
        i2c_stop();
        repeat (5) @(posedge clk); #1;
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL burst_pending got %0d required 0", exp_q.size()); end
        n_cmp++; if (lcd_byte !== 8'h7E) begin n_bad++; $display("FAIL burst_last_byte got %02h required 7E", lcd_byte); end
`ifdef DDRAM_EN
        for (int i = 0; i < 6; i++) begin
            rd_addr = ra[i]; repeat (2) @(posedge clk); #1;
            n_cmp++; if (rd_data !== rv[i]) begin n_bad++; $display("FAIL ddram_%0d got %02h required %02h", ra[i], rd_data, rv[i]); end
        end
`endif
        i2c_start();
        send_byte(8'h4E);
        put4(1'b0, 8'h01);
        i2c_stop();
        repeat (40) @(posedge clk); #1;
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL clear_pending got %0d required 0", exp_q.size()); end
`ifdef DDRAM_EN
        for (int i = 0; i < 6; i++) begin
            rd_addr = ra[i]; repeat (2) @(posedge clk); #1;
            n_cmp++; if (rd_data !== 8'h20) begin n_bad++; $display("FAIL cleared_%0d got %02h required 20", ra[i], rd_data); end
        end
`else
        n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL rd_data_tied got %02h required 00", rd_data); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int n0;
        b = 8'h9D;
        i2c_start();
        send_byte(8'h4E);
        for (int i = 7; i >= 4; i--) send_bit(b[i]);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (sda !== 1'b1) begin n_bad++; $display("FAIL midrst_sda got %0b required 1", sda); end
        n_cmp++; if (port_q !== 8'h00) begin n_bad++; $display("FAIL midrst_port_q got %02h required 00", port_q); end
        n_cmp++; if (mode4 !== 1'b0) begin n_bad++; $display("FAIL midrst_mode4 got %0b required 0", mode4); end
        n_cmp++; if (lcd_byte !== 8'h00) begin n_bad++; $display("FAIL midrst_lcd_byte got %02h required 00", lcd_byte); end
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        drv_seen = 1'b0;
        for (int i = 3; i >= 0; i--) send_bit(b[i]);
        send_bit(1'b1);
        i2c_stop();
        n_cmp++; if (drv_seen !== 1'b0) begin n_bad++; $display("FAIL midrst_ignored got driven=%0b required 0", drv_seen); end
        n0 = nacks;
        i2c_start();
        send_byte(8'h4E);
        send_byte(8'h3C);
        exp_q.push_back({1'b0, 8'h30});
        send_byte(8'h38);
        i2c_stop();
        repeat (5) @(posedge clk); #1;
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL postrst_pending got %0d required 0", exp_q.size()); end
        n_cmp++; if (nacks !== n0) begin n_bad++; $display("FAIL postrst_nacks got %0d required %0d", nacks, n0); end
        n_cmp++; if (port_q !== 8'h38) begin n_bad++; $display("FAIL postrst_port_q got %02h required 38", port_q); end
        n_cmp++; if (mode4 !== 1'b0) begin n_bad++; $display("FAIL postrst_mode4 got %0b required 0", mode4); end
    endtask

    initial begin
        test_reset();
        test_addr_ack();
        test_addr_mismatch();
        test_init();
        test_cmd_data();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lcd_1602_rx.md
Name: lcd_1602_rx

Overview:
- I2C target emulating a PCF8574 LCD backpack plus the HD44780 nibble interface behind it.
- Decodes the byte stream produced by the LCD writer into complete LCD commands and characters.
- Used as a bench/loopback peer on the shared sda/sclk bus and as an on-chip display mirror.
- Sits on the same bus as the i2c master, opposite end from the LCD writer.

Parameters:
- ADDR, 7'h27, 7-bit target address.
- SYNC, 2, synchronizer flops on scl/sda inputs (2..3).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sclk  in  1  I2C clock from master.
- sda  inout  1  I2C data; open-drain, driven only '0' or 'z'.
- port_q  out  8  last data byte received (expander pin image).
- lcd_valid  out  1  one-clk pulse: new LCD transfer complete.
- lcd_rs  out  1  RS of that transfer (0 = command, 1 = data).
- lcd_byte  out  8  assembled command/character.
- mode4  out  1  1 once function-set DL=0 has been decoded.
- addressed  out  1  high from address ACK until STOP/repeated START.
- rd_addr  in  5  DDRAM mirror read address (DDRAM_EN only).
- rd_data  out  8  DDRAM mirror read data, registered (DDRAM_EN only).

Behaviour:
- Reset values:
  - port_q = 8'h00, lcd_valid = 0, lcd_rs = 0, lcd_byte = 0, mode4 = 0, addressed = 0.
  - sda released; nibble phase = high; DDRAM cleared to 8'h20; cursor = 0.
- Inputs pass through SYNC flops; all edge detection uses the synchronized values.
- START = sda fall while sclk high. STOP = sda rise while sclk high. Both are honoured in any state.
- Bit sampling: sda is sampled on the synced sclk rise, MSB first.
- sda drive changes only on the synced sclk fall.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE -> ADDR on START.
  - ADDR: after 8 bits, if addr == ADDR and R/W = 0, go to ADDR_ACK. Otherwise (mismatch or read) go to IGNORE; sda is never driven for reads.
  - ADDR_ACK: pull sda low from the 8th sclk fall to the 9th sclk fall; addressed = 1; then go to DATA.
  - DATA: after 8 bits, port_q <= byte on the 8th rise; then go to DATA_ACK, which ACKs as above and returns to DATA.
  - IGNORE: wait for START or STOP.
  - STOP -> IDLE, addressed = 0, sda released. Repeated START -> ADDR.
  - START/STOP arriving mid-byte discards the partial byte; port_q keeps its old value.
- port_q bit map: [7:4] D7..D4, [3] BL, [2] EN, [1] RW, [0] RS.
- The LCD strobe is a falling EN across consecutive port_q updates (prev[2]=1, new[2]=0). It is evaluated the clk after port_q updates.
  - RW = 1 at the strobe: strobe ignored.
  - Strobe nibble = prev[7:4]; RS = prev[0].
- mode4 = 0 (8-bit init mode):
  - Each strobe is a full transfer; lcd_byte = {nibble, 4'h0}.
  - A command with nibble 4'h2 sets mode4 = 1 and resets the phase to high.
- mode4 = 1:
  - First strobe latches the high nibble; the second completes lcd_byte = {hi, lo} with RS taken from the second strobe.
  - Phase toggles each strobe; the phase is not reset by STOP.
- Latency: lcd_valid is asserted 2 clk after the sclk rise carrying bit 0 of the completing byte; width is 1 clk.
- rst mid-transaction: all state is reset immediately and sda is released the next clk. Bus activity is ignored until the next START.
- Write bursts have no length limit. port_q updates on every byte, even with no EN change.

Optional Feature:
- Macro DDRAM_EN.
- Defined:
  - 32x8 mirror: row 0 = DDRAM 0x00..0x0F, row 1 = 0x40..0x4F.
  - Command 8'b1xxxxxxx sets the cursor: addr[6] selects the row, addr[3:0] the column. So 8'h80→0, 8'h88→8, 8'hC0→16, 8'hC8→24.
  - Each RS=1 transfer writes lcd_byte at the cursor, then cursor = {row, col+1}; the column wraps 15→0 within the row.
  - Command 8'h01 fills the mirror with 8'h20 and sets cursor = 0 (a 32-clk sweep; transfers during the sweep are queued, depth 1).
  - rd_data = mem[rd_addr], 1-clk latency.
- Undefined: rd_addr unused; rd_data tied to 8'h00; no storage is inferred.

Decomposition:
- Package lcd_rx_t holds:
  - state enum rx_state_t;
  - bit-position constants P_RS=0, P_RW=1, P_EN=2, P_BL=3;
  - DDRAM row bases 7'h00 and 7'h40;
  - CMD_CLEAR=8'h01 and CMD_SET_DDRAM mask 8'h80.
- Sub-module i2c_target_phy handles the synchronizers, START/STOP detection, shift register, address match and ACK drive. It outputs byte_valid/byte/addressed.
- The lcd_1602_rx top handles EN strobe decode, nibble assembly and the DDRAM mirror.

Test Plan:
- START, 8'h4E, STOP → ACK on the 9th bit, addressed pulses, port_q unchanged, no lcd_valid.
- START, 8'h4A (addr 0x25) then 8'h3C → sda never driven; port_q stays 8'h00.
- Init 8'h3C,8'h38 ×3 then 8'h2C,8'h28 → three lcd_valid with RS=0 and byte 8'h30, then 8'h20 with mode4=1.
- In 4-bit mode, write 8'h8C,8'h88,8'h8C,8'h88 (cmd 0x88) then 8'h4D,8'h49,8'h1D,8'h19 → lcd_byte 8'h88 RS=0, then 8'h41 RS=1. With DDRAM_EN, rd_addr=8 returns 8'h41.
- STOP after the second byte of a nibble pair, then a new transaction with the remaining bytes → phase is preserved; the 8'h41 still completes.
- rst asserted between bit 3 and bit 4 of a data byte → sda released next clk, outputs return to reset values, the next full write decodes correctly.
